// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-client SDRAM user-port arbiter:
// default widths, watchdog limit and FSM state encoding.
package sdram_arb_pkg;

  localparam int DEF_ADDR_W      = 24;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_LEN_W       = 9;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_CMD  = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } arb_state_e;

  // Bits needed to hold a watchdog count of 0..cyc.
  function automatic int wdog_width(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/sdram_rr_arb.sv
// Two-way round-robin grant. Purely combinational; the parent keeps the
// index of the last served client and feeds it back as 'last'.
module sdram_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Both asking: the client that was not served last goes first.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the sdram_top user port between client 0 (CPU) and client 1 (video/DMA),
// granting whole bursts round-robin and aborting bursts that stop making progress.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk_50m,
  input  logic              rst_n,

  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [LEN_W-1:0]  c0_len,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_wdata_ack,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_rvalid,
  output logic              c0_done,
  output logic              c0_err,

  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [LEN_W-1:0]  c1_len,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_wdata_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_rvalid,
  output logic              c1_done,
  output logic              c1_err,

  input  logic              sdram_init_done,
  input  logic              sdram_busy,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [LEN_W-1:0]  sdwr_bytes,
  output logic [LEN_W-1:0]  sdrd_bytes,
  output logic [DATA_W-1:0] sdram_wr_data,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  input  logic [DATA_W-1:0] sdram_rd_data,

  output logic [2:0]        dbg_state
);

  // Handshake: a client holds cN_req with stable we/addr/len until its one-cycle
  // cN_done; each sdram_*_ack moves exactly one word, and wdata_ack/rvalid mirror
  // those acks only toward the granted client while a burst is in flight.

  localparam int WDOG_W = wdog_width(TIMEOUT_CYC);
  // The ack cycle itself is progress; abort after TIMEOUT_CYC quiet cycles.
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC - 1);

  arb_state_e        state;
  logic              last_q;
  logic [1:0]        gnt_q;
  logic              we_q;
  logic [LEN_W-1:0]  remain;
  logic [WDOG_W-1:0] wdog;

  logic [1:0]        arb_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              active;
  logic              cur_ack;
  logic              last_ack;
  logic              timeout;

  sdram_rr_arb u_rr_arb (
    .req  ({c1_req, c0_req}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    sel_we   = arb_gnt[1] ? c1_we   : c0_we;
    sel_addr = arb_gnt[1] ? c1_addr : c0_addr;
    sel_len  = arb_gnt[1] ? c1_len  : c0_len;
    active   = (state == ST_CMD) || (state == ST_XFER);
    cur_ack  = we_q ? sdram_wr_ack : sdram_rd_ack;
    last_ack = active && cur_ack && (remain == LEN_W'(1));
    timeout  = active && !cur_ack && (wdog == WDOG_LIMIT);
  end

  // Data steering; acks outside CMD/XFER belong to nobody.
  assign c0_wdata_ack  = sdram_wr_ack & gnt_q[0] & active;
  assign c1_wdata_ack  = sdram_wr_ack & gnt_q[1] & active;
  assign c0_rvalid     = sdram_rd_ack & gnt_q[0] & active;
  assign c1_rvalid     = sdram_rd_ack & gnt_q[1] & active;
  assign c0_rdata      = active ? sdram_rd_data : '0;
  assign c1_rdata      = active ? sdram_rd_data : '0;
  assign sdram_wr_data = gnt_q[1] ? c1_wdata : (gnt_q[0] ? c0_wdata : '0);
  assign dbg_state     = state;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 2'b00;
      we_q          <= 1'b0;
      remain        <= '0;
      wdog          <= '0;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_rd_addr <= '0;
      sdwr_bytes    <= '0;
      sdrd_bytes    <= '0;
      c0_done       <= 1'b0;
      c1_done       <= 1'b0;
      c0_err        <= 1'b0;
      c1_err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gnt_q <= 2'b00;
          if ((c0_req || c1_req) && sdram_init_done && !sdram_busy) begin
            state <= ST_ARB;
          end
        end

        ST_ARB: begin
          if (arb_gnt == 2'b00) begin
            state <= ST_IDLE;
          end else begin
            gnt_q  <= arb_gnt;
            we_q   <= sel_we;
            remain <= sel_len;
            wdog   <= '0;
            if (sel_len == '0) begin
              // Nothing to move: report an aborted burst without touching SDRAM.
              state   <= ST_DONE;
              c0_done <= arb_gnt[0];
              c1_done <= arb_gnt[1];
              c0_err  <= arb_gnt[0];
              c1_err  <= arb_gnt[1];
            end else begin
              state        <= ST_CMD;
              sdram_wr_req <= sel_we;
              sdram_rd_req <= !sel_we;
              if (sel_we) begin
                sdram_wr_addr <= sel_addr;
                sdwr_bytes    <= sel_len;
              end else begin
                sdram_rd_addr <= sel_addr;
                sdrd_bytes    <= sel_len;
              end
            end
          end
        end

        ST_CMD, ST_XFER: begin
          if (cur_ack) begin
            // sdram_top has latched the command once the first word moves.
            remain       <= remain - LEN_W'(1);
            wdog         <= '0;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            state        <= (remain == LEN_W'(1)) ? ST_DONE : ST_XFER;
          end else if (wdog == WDOG_LIMIT) begin
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            state        <= ST_DONE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
          if (last_ack || timeout) begin
            c0_done <= gnt_q[0];
            c1_done <= gnt_q[1];
            c0_err  <= timeout & gnt_q[0];
            c1_err  <= timeout & gnt_q[1];
          end
        end

        ST_DONE: begin
          c0_done <= 1'b0;
          c1_done <= 1'b0;
          c0_err  <= 1'b0;
          c1_err  <= 1'b0;
          last_q  <= gnt_q[1];
          gnt_q   <= 2'b00;
          wdog    <= '0;
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a responding SDRAM model, client drivers, and a
// scoreboard of expected commands, data words and done/err results.
module tb_sdram_arbiter;

  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 16;
  localparam int LEN_W       = 9;
  localparam int TIMEOUT_CYC = 4096;

  logic              clk_50m = 1'b0;
  logic              rst_n   = 1'b0;
  logic              c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
  logic [ADDR_W-1:0] c0_addr = '0, c1_addr = '0;
  logic [LEN_W-1:0]  c0_len = '0, c1_len = '0;
  logic [DATA_W-1:0] c0_wdata = '0, c1_wdata = '0;
  logic              c0_wdata_ack, c0_rvalid, c0_done, c0_err;
  logic              c1_wdata_ack, c1_rvalid, c1_done, c1_err;
  logic [DATA_W-1:0] c0_rdata, c1_rdata;
  logic              sdram_init_done = 1'b0, sdram_busy = 1'b0;
  logic              sdram_wr_req, sdram_rd_req;
  logic [ADDR_W-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [LEN_W-1:0]  sdwr_bytes, sdrd_bytes;
  logic [DATA_W-1:0] sdram_wr_data;
  logic              sdram_wr_ack, sdram_rd_ack;
  logic [DATA_W-1:0] sdram_rd_data;
  logic [2:0]        dbg_state;

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_len(c0_len),
    .c0_wdata(c0_wdata), .c0_wdata_ack(c0_wdata_ack), .c0_rdata(c0_rdata),
    .c0_rvalid(c0_rvalid), .c0_done(c0_done), .c0_err(c0_err),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_len(c1_len),
    .c1_wdata(c1_wdata), .c1_wdata_ack(c1_wdata_ack), .c1_rdata(c1_rdata),
    .c1_rvalid(c1_rvalid), .c1_done(c1_done), .c1_err(c1_err),
    .sdram_init_done(sdram_init_done), .sdram_busy(sdram_busy),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .sdwr_bytes(sdwr_bytes), .sdrd_bytes(sdrd_bytes),
    .sdram_wr_data(sdram_wr_data), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_ack(sdram_rd_ack), .sdram_rd_data(sdram_rd_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0]        exp_q[$];      // {client, word}
  logic [1:0]             exp_done_q[$]; // {client, err}
  logic [ADDR_W+LEN_W:0]  exp_cmd_q[$];  // {we, addr, len}

  int n_checks = 0, n_pass = 0;
  int wack_cnt[2] = '{0, 0};
  int rv_cnt[2]   = '{0, 0};
  int done_cnt[2] = '{0, 0};
  int done_cyc[2] = '{0, 0};
  int cmd_cnt = 0, req_cyc = 0, last_ack_cyc = 0;
  int ack_limit = 1000;
  logic [DATA_W-1:0] wbase[2] = '{16'h0, 16'h0};
  int widx[2] = '{0, 0};
  logic adv[2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [DATA_W-1:0] wword(input logic [DATA_W-1:0] b, input int k);
    return b + DATA_W'(k * 257);
  endfunction

  function automatic logic any_out();
    return |{c0_wdata_ack, c0_rdata, c0_rvalid, c0_done, c0_err,
             c1_wdata_ack, c1_rdata, c1_rvalid, c1_done, c1_err,
             sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
             sdwr_bytes, sdrd_bytes, sdram_wr_data};
  endfunction

  task automatic pop_data(input string tag, input logic [DATA_W:0] obs);
    check({tag, "_expected"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check(tag, obs, exp_q.pop_front());
  endtask

  task automatic pop_done(input string tag, input logic [1:0] obs);
    check({tag, "_expected"}, exp_done_q.size() != 0, 1);
    if (exp_done_q.size() != 0) check(tag, obs, exp_done_q.pop_front());
  endtask

  // ---------------- SDRAM model: one ack per cycle, read word = addr + k ----------------
  int m_left = 0, m_k = 0;
  logic m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;

  initial begin : sdram_model
    sdram_wr_ack  = 1'b0;
    sdram_rd_ack  = 1'b0;
    sdram_rd_data = '0;
    forever begin
      @(negedge clk_50m);
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
      if (!rst_n) begin
        m_left = 0;
      end else begin
        if (m_left == 0 && (sdram_wr_req || sdram_rd_req)) begin
          m_we   = sdram_wr_req;
          m_addr = sdram_wr_req ? sdram_wr_addr : sdram_rd_addr;
          m_left = int'(sdram_wr_req ? sdwr_bytes : sdrd_bytes);
          if (m_left > ack_limit) m_left = ack_limit;
          m_k = 0;
        end
        if (m_left > 0) begin
          if (m_we) begin
            sdram_wr_ack = 1'b1;
          end else begin
            sdram_rd_ack  = 1'b1;
            sdram_rd_data = m_addr[DATA_W-1:0] + DATA_W'(m_k);
          end
          m_k++;
          m_left--;
        end
      end
    end
  end

  // ---------------- monitor + client write-data advance ----------------
  initial begin : monitor
    logic req_prev;
    logic req_now;
    logic [ADDR_W+LEN_W:0] cmd_obs;
    req_prev = 1'b0;
    forever begin
      @(negedge clk_50m);
      #1;
      if (adv[0]) begin widx[0]++; c0_wdata = wword(wbase[0], widx[0]); adv[0] = 1'b0; end
      if (adv[1]) begin widx[1]++; c1_wdata = wword(wbase[1], widx[1]); adv[1] = 1'b0; end
      #1;
      if (!rst_n) begin
        req_prev = 1'b0;
        adv[0]   = 1'b0;
        adv[1]   = 1'b0;
      end else begin
        req_now = sdram_wr_req || sdram_rd_req;
        if (req_now && !req_prev) begin
          cmd_cnt++;
          req_cyc = cyc;
          cmd_obs = sdram_wr_req ? {1'b1, sdram_wr_addr, sdwr_bytes}
                                 : {1'b0, sdram_rd_addr, sdrd_bytes};
          check("cmd_expected", exp_cmd_q.size() != 0, 1);
          if (exp_cmd_q.size() != 0) check("cmd", cmd_obs, exp_cmd_q.pop_front());
        end
        req_prev = req_now;
        if (sdram_wr_ack || sdram_rd_ack) last_ack_cyc = cyc;
        if (c0_wdata_ack) begin wack_cnt[0]++; adv[0] = 1'b1; pop_data("wdata_c0", {1'b0, sdram_wr_data}); end
        if (c1_wdata_ack) begin wack_cnt[1]++; adv[1] = 1'b1; pop_data("wdata_c1", {1'b1, sdram_wr_data}); end
        if (c0_rvalid) begin rv_cnt[0]++; pop_data("rdata_c0", {1'b0, c0_rdata}); end
        if (c1_rvalid) begin rv_cnt[1]++; pop_data("rdata_c1", {1'b1, c1_rdata}); end
        if (c0_err || c1_err) check("err_with_done", (c0_err & c0_done) | (c1_err & c1_done), 1);
        if (c0_done) begin done_cnt[0]++; done_cyc[0] = cyc; pop_done("done_c0", {1'b0, c0_err}); end
        if (c1_done) begin done_cnt[1]++; done_cyc[1] = cyc; pop_done("done_c1", {1'b1, c1_err}); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_50m);
      #3;
    end
  endtask

  task automatic start_burst(input int c, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] base);
    int n;
    n = (int'(len) > ack_limit) ? ack_limit : int'(len);
    if (len != '0) exp_cmd_q.push_back({we, addr, len});
    for (int k = 0; k < n; k++) begin
      if (we) exp_q.push_back({c[0], wword(base, k)});
      else    exp_q.push_back({c[0], addr[DATA_W-1:0] + DATA_W'(k)});
    end
    exp_done_q.push_back({c[0], (len == '0) || (int'(len) > ack_limit)});
    wbase[c] = base;
    widx[c]  = 0;
    if (c == 0) begin
      c0_we = we; c0_addr = addr; c0_len = len; c0_wdata = base; c0_req = 1'b1;
    end else begin
      c1_we = we; c1_addr = addr; c1_len = len; c1_wdata = base; c1_req = 1'b1;
    end
  endtask

  task automatic wait_done(input int c, input int budget);
    int start;
    start = done_cnt[c];
    for (int i = 0; i < budget && done_cnt[c] == start; i++) step(1);
    check((c == 0) ? "done_seen_c0" : "done_seen_c1", done_cnt[c] - start, 1);
    if (c == 0) c0_req = 1'b0;
    else        c1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    c0_req = 1'b0;
    c1_req = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int n0, w0, w1, r0, r1, cmd0, t0, c0d;

    // Reset values, with live-looking inputs around the DUT.
    #1;
    check("reset_outputs", any_out(), 0);
    check("reset_state", dbg_state, 0);
    step(3);
    rst_n = 1'b1;
    step(1);
    check("post_reset_outputs", any_out(), 0);

    // Init gating, then a full 256-word write from client 1.
    w1 = wack_cnt[1];
    r0 = rv_cnt[0];
    start_burst(1, 1'b1, 24'h1F_0000, 9'h100, 16'h3C00);
    step(1000);
    check("init_gate_no_cmd", cmd_cnt, 0);
    check("init_gate_idle", dbg_state, 0);
    n0 = cyc;
    sdram_init_done = 1'b1;
    wait_done(1, 600);
    check("init_grant_latency", req_cyc - n0, 2);
    check("full_wack_count", wack_cnt[1] - w1, 256);
    check("full_done_latency", done_cyc[1] - last_ack_cyc, 1);
    check("full_no_rvalid", rv_cnt[0] - r0, 0);

    // Single one-word write from client 0.
    w0 = wack_cnt[0];
    step(2);
    n0 = cyc;
    start_burst(0, 1'b1, 24'h00_0400, 9'd1, 16'h000F);
    wait_done(0, 50);
    check("single_grant_latency", req_cyc - n0, 2);
    check("single_wack_count", wack_cnt[0] - w0, 1);
    check("single_done_latency", done_cyc[0] - last_ack_cyc, 1);

    // Simultaneous reads from reset; client 0 re-requests at its done.
    do_reset();
    step(1);
    r0 = rv_cnt[0];
    r1 = rv_cnt[1];
    start_burst(0, 1'b0, 24'h00_0100, 9'd4, 16'h0);
    start_burst(1, 1'b0, 24'h02_0200, 9'd4, 16'h0);
    wait_done(0, 50);
    check("simul_c0_rvalid", rv_cnt[0] - r0, 4);
    check("simul_c1_idle", rv_cnt[1] - r1, 0);
    t0  = last_ack_cyc;
    c0d = done_cyc[0];
    start_burst(0, 1'b0, 24'h00_0300, 9'd2, 16'h0);
    wait_done(1, 50);
    check("simul_c1_rvalid", rv_cnt[1] - r1, 4);
    check("simul_done_gap", (done_cyc[1] - c0d) >= 3, 1);
    check("next_grant_latency", req_cyc - t0, 4);
    wait_done(0, 50);
    check("simul_c0_second", rv_cnt[0] - r0, 6);

    // Watchdog abort: model stops after 3 acks.
    step(2);
    r0 = rv_cnt[0];
    ack_limit = 3;
    start_burst(0, 1'b0, 24'h00_0800, 9'd8, 16'h0);
    wait_done(0, TIMEOUT_CYC + 100);
    check("timeout_latency", done_cyc[0] - last_ack_cyc, TIMEOUT_CYC + 1);
    check("timeout_rvalid", rv_cnt[0] - r0, 3);
    ack_limit = 1000;

    // Zero-length request: error, no SDRAM command.
    step(2);
    cmd0 = cmd_cnt;
    start_burst(0, 1'b0, 24'h12_3456, 9'd0, 16'h0);
    wait_done(0, 20);
    check("len0_no_cmd", cmd_cnt - cmd0, 0);

    // Reset in the middle of a write burst.
    step(2);
    w0 = wack_cnt[0];
    start_burst(0, 1'b1, 24'h00_2000, 9'd16, 16'h5A00);
    for (int i = 0; i < 50 && (wack_cnt[0] - w0) < 3; i++) step(1);
    check("mid_burst_progress", (wack_cnt[0] - w0) >= 3, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", any_out(), 0);
    check("mid_reset_state", dbg_state, 0);
    c0_req = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    exp_cmd_q.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
    r1 = rv_cnt[1];
    n0 = cyc;
    start_burst(1, 1'b0, 24'h03_0010, 9'd3, 16'h0);
    wait_done(1, 50);
    check("after_reset_latency", req_cyc - n0, 2);
    check("after_reset_rvalid", rv_cnt[1] - r1, 3);

    step(3);
    check("data_q_drained", exp_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
    check("cmd_q_drained", exp_cmd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
